// File: rtl/set_bit_scanner.sv
// set_bit_scanner: captures a vector, then streams the index of each set bit,
// one beat per cycle, lowest-first (or highest-first when MSB_FIRST=1).
module set_bit_scanner #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned POS_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_last,
    output logic             out_none
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   w_work_nxt;
    logic [WIDTH-1:0]   w_clr_mask;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [POS_W-1:0]   r_pos;
    logic               r_last;
    logic               r_none;
    logic               w_scan_nxt;
    logic [POS_W-1:0]   w_pos_nxt;
    logic               w_last_nxt;
    logic               w_none_nxt;

    // Index of the set bit to emit first from v (0 when v is all-zero).
    function automatic logic [POS_W-1:0] find_pos(input logic [WIDTH-1:0] v);
        logic [POS_W-1:0] pos;
        pos = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (v[i]) pos = POS_W'(i);
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (v[i]) pos = POS_W'(i);
            end
        end
        return pos;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // Bit of the beat currently on the output, cleared once it is accepted.
    assign w_clr_mask = WIDTH'(1) << r_pos;

    // Next state, next work vector, and the beat that the next state will present.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_work_nxt  = in_data;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    w_work_nxt = r_work & ~w_clr_mask;
                    if (r_last) w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_scan_nxt = (w_state_nxt == ST_SCAN);
        w_none_nxt = w_scan_nxt && (w_work_nxt == '0);
        w_last_nxt = w_none_nxt || (w_scan_nxt && is_onehot(w_work_nxt));
        w_pos_nxt  = w_scan_nxt ? find_pos(w_work_nxt) : '0;
    end

    // State, work register and registered outputs; reset dominates handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_pos       <= '0;
            r_last      <= 1'b0;
            r_none      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_work      <= w_work_nxt;
            r_in_ready  <= ~w_scan_nxt;
            r_out_valid <= w_scan_nxt;
            r_pos       <= w_pos_nxt;
            r_last      <= w_last_nxt;
            r_none      <= w_none_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pos   = r_pos;
    assign out_last  = r_last;
    assign out_none  = r_none;

endmodule

// File: tb/tb_set_bit_scanner.sv
// Bench for set_bit_scanner: three configurations (8/LSB, 8/MSB, 16/LSB)
// checked every cycle against a list-based model, plus directed literal checks.
module tb_set_bit_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid  [3];
    logic [15:0] in_data   [3];
    logic        out_ready [3];
    logic        rdy_a     [3];
    logic        vld_a     [3];
    logic        last_a    [3];
    logic        none_a    [3];
    logic [3:0]  pos_a     [3];
    logic [2:0]  pos0, pos1;
    logic [3:0]  pos2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    set_bit_scanner #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(rdy_a[0]), .in_data(in_data[0][7:0]),
        .out_valid(vld_a[0]), .out_ready(out_ready[0]), .out_pos(pos0),
        .out_last(last_a[0]), .out_none(none_a[0])
    );
    set_bit_scanner #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(rdy_a[1]), .in_data(in_data[1][7:0]),
        .out_valid(vld_a[1]), .out_ready(out_ready[1]), .out_pos(pos1),
        .out_last(last_a[1]), .out_none(none_a[1])
    );
    set_bit_scanner #(.WIDTH(16), .MSB_FIRST(1'b0)) u_l16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(rdy_a[2]), .in_data(in_data[2]),
        .out_valid(vld_a[2]), .out_ready(out_ready[2]), .out_pos(pos2),
        .out_last(last_a[2]), .out_none(none_a[2])
    );

    assign pos_a[0] = {1'b0, pos0};
    assign pos_a[1] = {1'b0, pos1};
    assign pos_a[2] = pos2;

    function automatic int width_of(input int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic bit msb_of(input int k);
        return (k == 1);
    endfunction

    function automatic int popcnt(input int k, input logic [15:0] d);
        int c = 0;
        for (int j = 0; j < width_of(k); j++) if (d[j]) c++;
        return c;
    endfunction

    // n-th index in emission order (ascending, or descending for MSB-first).
    function automatic int nth_index(input int k, input logic [15:0] d, input int n);
        int seen = 0;
        int w = width_of(k);
        for (int j = 0; j < w; j++) begin
            int idx = msb_of(k) ? (w - 1 - j) : j;
            if (d[idx]) begin
                if (seen == n) return idx;
                seen++;
            end
        end
        return 0;
    endfunction

    // Model: a busy flag plus the list of indices still to emit.
    bit m_busy [3];
    bit m_none [3];
    int m_cnt  [3];
    int m_head [3];
    int m_list [3][16];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_busy[k] <= 1'b0;
            end else if (m_busy[k]) begin
                if (out_ready[k]) begin
                    if (m_none[k] || (m_head[k] == m_cnt[k] - 1)) m_busy[k] <= 1'b0;
                    else m_head[k] <= m_head[k] + 1;
                end
            end else if (in_valid[k]) begin
                m_busy[k] <= 1'b1;
                m_head[k] <= 0;
                m_cnt[k]  <= popcnt(k, in_data[k]);
                m_none[k] <= (popcnt(k, in_data[k]) == 0);
                for (int i = 0; i < 16; i++) m_list[k][i] <= nth_index(k, in_data[k], i);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                int e_pos;
                int e_last;
                e_pos  = (m_busy[k] && !m_none[k]) ? m_list[k][m_head[k]] : 0;
                e_last = m_busy[k] && (m_none[k] || (m_head[k] == m_cnt[k] - 1));
                check($sformatf("k%0d_in_ready", k), int'(rdy_a[k]), int'(!m_busy[k]));
                check($sformatf("k%0d_out_valid", k), int'(vld_a[k]), int'(m_busy[k]));
                check($sformatf("k%0d_out_pos", k), int'(pos_a[k]), e_pos);
                check($sformatf("k%0d_out_last", k), int'(last_a[k]), e_last);
                check($sformatf("k%0d_out_none", k), int'(none_a[k]), int'(m_busy[k] && m_none[k]));
            end
        end
    end

    // Present one vector when the instance is idle; returns with its first beat visible.
    task automatic send(input int k, input logic [15:0] d);
        int n = 0;
        while (!rdy_a[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_wait_timeout", 0, 1);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic beat(input string nm, input int k, input int p, input int l, input int z);
        check({nm, "_valid"}, int'(vld_a[k]), 1);
        check({nm, "_pos"}, int'(pos_a[k]), p);
        check({nm, "_last"}, int'(last_a[k]), l);
        check({nm, "_none"}, int'(none_a[k]), z);
    endtask

    task automatic idle_chk(input string nm, input int k);
        check({nm, "_in_ready"}, int'(rdy_a[k]), 1);
        check({nm, "_valid"}, int'(vld_a[k]), 0);
        check({nm, "_pos"}, int'(pos_a[k]), 0);
        check({nm, "_last"}, int'(last_a[k]), 0);
        check({nm, "_none"}, int'(none_a[k]), 0);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        idle_chk("reset_l8", 0);
        idle_chk("reset_m8", 1);
        idle_chk("reset_l16", 2);

        // 1010_0100 -> 2, 5, 7
        send(0, 16'h00A4);
        beat("a4_b0", 0, 2, 0, 0);
        @(negedge clk); beat("a4_b1", 0, 5, 0, 0);
        @(negedge clk); beat("a4_b2", 0, 7, 1, 0);
        check("a4_last_in_ready", int'(rdy_a[0]), 0);
        @(negedge clk); idle_chk("a4_after", 0);

        // zero vector -> single none beat
        send(0, 16'h0000);
        beat("zero", 0, 0, 1, 1);
        @(negedge clk); idle_chk("zero_after", 0);

        // backpressure on 0001_0100
        out_ready[0] = 1'b0;
        send(0, 16'h0014);
        beat("bp_c0", 0, 2, 0, 0);
        @(negedge clk); beat("bp_c1", 0, 2, 0, 0);
        @(negedge clk); beat("bp_c2", 0, 2, 0, 0);
        out_ready[0] = 1'b1;
        @(negedge clk); beat("bp_b1", 0, 4, 1, 0);
        @(negedge clk); idle_chk("bp_after", 0);

        // MSB-first 1000_0001, input changed after accept
        send(1, 16'h0081);
        in_data[1] = 16'h00FF;
        beat("msb_b0", 1, 7, 0, 0);
        @(negedge clk); beat("msb_b1", 1, 0, 1, 0);
        @(negedge clk); idle_chk("msb_after", 1);

        // reset after the second beat of 8'hFF
        send(0, 16'h00FF);
        beat("ff_b0", 0, 0, 0, 0);
        @(negedge clk); beat("ff_b1", 0, 1, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_chk("midrst", 0);
        send(0, 16'h0010);
        beat("post_rst", 0, 4, 1, 0);
        @(negedge clk);

        // 16-bit boundaries
        send(2, 16'h8000);
        beat("w16_top", 2, 15, 1, 0);
        @(negedge clk);
        send(2, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            beat($sformatf("w16_ones_%0d", i), 2, i, int'(i == 15), 0);
            @(negedge clk);
        end
        idle_chk("w16_after", 2);

        // randomized traffic on all three instances
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                int sel;
                sel = $urandom_range(0, 7);
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                out_ready[k] = ($urandom_range(0, 3) != 0);
                case (sel)
                    0:       in_data[k] = 16'h0000;
                    1:       in_data[k] = 16'hFFFF;
                    2:       in_data[k] = 16'h8000 >> (16 - width_of(k));
                    3:       in_data[k] = 16'(1) << $urandom_range(0, width_of(k) - 1);
                    default: in_data[k] = 16'($urandom);
                endcase
            end
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end

        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("drain_k%0d", k), int'(rdy_a[k]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/set_bit_scanner.md
# set_bit_scanner

Parametrised, sequential priority-encoder engine. It accepts a WIDTH-bit vector over a valid/ready handshake and then emits the index of every set bit, one beat per cycle, on a downstream valid/ready stream. The default order is lowest index first; MSB_FIRST selects highest index first. It serves as the iterating successor to the single-shot combinational "first set bit" encoder, for request vectors, interrupt pending masks and free-slot bitmaps.

## Interface
- WIDTH, 8: input vector width; legal range 2..256.
- MSB_FIRST, 0: 0 = emit lowest set index first; 1 = emit highest set index first.
- POS_W (localparam), $clog2(WIDTH): width of the position output.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  WIDTH  vector to scan.
- out_valid  out  1  position beat valid.
- out_ready  in  1  downstream accepts beat.
- out_pos  out  POS_W  index of the current set bit.
- out_last  out  1  current beat is the final beat for this vector.
- out_none  out  1  input vector was all-zero; this is the sole beat.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- IDLE, in_valid=1: the vector is captured into the work register `work`, and the block moves to SCAN.
- Zero vector: the block still moves to SCAN and emits exactly one beat with out_none=1, out_last=1, out_pos=0.
- SCAN, non-zero `work`:
  - out_pos = index of the lowest set bit of `work` (MSB_FIRST=0) or the highest set bit (MSB_FIRST=1).
  - out_last=1 iff exactly one bit of `work` is set.
  - out_none=0.
- SCAN, out_valid&&out_ready:
  - The bit at out_pos is cleared in `work`.
  - If out_last=1, the block returns to IDLE; otherwise it stays in SCAN.
- Output derivation:
  - All outputs are functions of registered state only. There is no combinational path from in_* to out_*, or from out_ready to in_ready.
  - out_pos, out_last and out_none are don't-care-free: they are driven to 0 whenever out_valid=0.
- Beat ordering: strictly monotonic per vector; ascending for MSB_FIRST=0, descending for MSB_FIRST=1. Each set bit is emitted exactly once.
- Input capture: in_data is sampled only on the accepting edge. Later changes to in_data have no effect on the vector being scanned.

## Timing
- Reset:
  - Takes effect on the rising edge with reset=1 and has priority over all handshakes.
  - After the edge: state=IDLE, `work`=0, in_ready=1, out_valid=0, out_pos=0, out_last=0, out_none=0.
- Latency: first out_valid appears in the cycle after the in_valid&&in_ready edge.
- Throughput:
  - A vector with N set bits (N≥1) occupies N SCAN cycles plus one IDLE cycle, assuming out_ready held at 1.
  - A zero vector occupies 1 SCAN cycle plus 1 IDLE cycle.
  - There is no overlap between consecutive vectors: in_ready is 0 throughout SCAN, including the cycle in which the last beat is accepted.
- Backpressure: while out_valid=1 and out_ready=0, out_pos, out_last, out_none and `work` hold stable.
- Reset mid-scan: remaining bits are discarded. The next cycle has out_valid=0 and in_ready=1, and no partial beat is emitted.
- Width boundaries:
  - Bit WIDTH-1 set yields out_pos=WIDTH-1 with no truncation.
  - An all-ones vector yields WIDTH beats, with out_last only on the final beat.

## Test plan
- WIDTH=8, MSB_FIRST=0, in_data=8'b1010_0100, out_ready=1 -> beats out_pos=2, 5, 7 on consecutive cycles; out_last=1 only on 7; in_ready=1 on the following cycle.
- in_data=8'h00 -> single beat: out_none=1, out_last=1, out_pos=0; then IDLE.
- in_data=8'b0001_0100 with out_ready=0 for 3 cycles -> out_pos=2 held stable with out_valid=1 for 3 cycles; then out_ready=1 -> beats 2, 4, in that order.
- MSB_FIRST=1, in_data=8'b1000_0001 -> beats out_pos=7, then 0 (out_last=1); in_data changed after accept -> no effect.
- in_data=8'hFF, reset asserted after the second beat -> next cycle out_valid=0, in_ready=1, all outputs 0; a new vector 8'h10 then yields out_pos=4 with out_last=1.
- WIDTH=16, in_data=16'h8000 -> single beat out_pos=15, out_last=1; WIDTH=16, in_data=16'hFFFF -> 16 beats 0..15.
